// File: rtl/contador_modulo_hold.sv
// contador_modulo_hold: falling-edge modulo-N up/down counter with hold, parallel load and wrap pulse.
module contador_modulo_hold #(
  parameter int WIDTH  = 4,
  parameter int MODULO = 10
) (
  input  logic             CLK,
  input  logic             nCLEAR,
  input  logic             nHOLD,
  input  logic             UP,
  input  logic             LOAD,
  input  logic [WIDTH-1:0] D,
  output logic [WIDTH-1:0] Q,
  output logic             TC,
  output logic             WRAP
);
  localparam logic [WIDTH-1:0] LAST = WIDTH'(MODULO - 1);
  logic             at_end;
  logic             in_range;
  logic [WIDTH-1:0] count_val;
  assign at_end    = UP ? (Q == LAST) : (Q == '0);
  assign TC        = nHOLD & ~LOAD & at_end;
  // widened compare so MODULO == 2**WIDTH accepts every D
  assign in_range  = {1'b0, D} < (WIDTH + 1)'(MODULO);
  assign count_val = at_end ? (UP ? '0 : LAST) : (UP ? Q + 1'b1 : Q - 1'b1);
  always_ff @(negedge CLK or negedge nCLEAR) begin
    if (!nCLEAR) begin
      Q    <= '0;
      WRAP <= 1'b0;
    end else if (LOAD) begin
      Q    <= in_range ? D : '0;
      WRAP <= 1'b0;
    end else if (nHOLD) begin
      Q    <= count_val;
      WRAP <= at_end;
    end else begin
      WRAP <= 1'b0;
    end
  end
endmodule

// File: tb/tb_contador_modulo_hold.sv
// tb_contador_modulo_hold: directed checks of the modulo-10 counter and a two-stage cascade.
module tb_contador_modulo_hold;
  logic       clk = 1'b1;
  logic       n_clear, n_hold, up, load;
  logic [3:0] d, q;
  logic       tc, wrap;
  logic       c_clear;
  logic [3:0] lo_q, hi_q;
  logic       lo_tc, lo_wrap, hi_tc, hi_wrap;
  int errors = 0;
  int checks = 0;

  always #5 clk = ~clk;

  contador_modulo_hold #(.WIDTH(4), .MODULO(10)) dut (
    .CLK(clk), .nCLEAR(n_clear), .nHOLD(n_hold), .UP(up), .LOAD(load),
    .D(d), .Q(q), .TC(tc), .WRAP(wrap)
  );
  contador_modulo_hold #(.WIDTH(4), .MODULO(10)) lo (
    .CLK(clk), .nCLEAR(c_clear), .nHOLD(1'b1), .UP(1'b1), .LOAD(1'b0),
    .D(4'd0), .Q(lo_q), .TC(lo_tc), .WRAP(lo_wrap)
  );
  contador_modulo_hold #(.WIDTH(4), .MODULO(10)) hi (
    .CLK(clk), .nCLEAR(c_clear), .nHOLD(lo_tc), .UP(1'b1), .LOAD(1'b0),
    .D(4'd0), .Q(hi_q), .TC(hi_tc), .WRAP(hi_wrap)
  );

  task automatic step();
    @(negedge clk);
    #1;
  endtask

  task automatic do_reset();
    n_clear = 1'b0;
    #2;
    n_clear = 1'b1;
    #1;
  endtask

  task automatic test_reset();
    n_clear = 1'b0; n_hold = 1'b1; up = 1'b1; load = 1'b0; d = 4'd0;
    #2;
    checks++; if (q !== 4'd0) begin errors++; $display("FAIL reset_q got=%0d exp=0", q); end
    checks++; if (wrap !== 1'b0) begin errors++; $display("FAIL reset_wrap got=%0b exp=0", wrap); end
    checks++; if (tc !== 1'b0) begin errors++; $display("FAIL reset_tc_up got=%0b exp=0", tc); end
    up = 1'b0; #1;
    checks++; if (tc !== 1'b1) begin errors++; $display("FAIL reset_tc_down got=%0b exp=1", tc); end
    up = 1'b1;
    step();
    checks++; if (q !== 4'd0) begin errors++; $display("FAIL reset_held got=%0d exp=0", q); end
    n_clear = 1'b1;
    repeat (7) step();
    checks++; if (q !== 4'd7) begin errors++; $display("FAIL count_to_7 got=%0d exp=7", q); end
    #2; n_clear = 1'b0; #1;
    checks++; if (q !== 4'd0) begin errors++; $display("FAIL reset_mid_q got=%0d exp=0", q); end
    checks++; if (wrap !== 1'b0) begin errors++; $display("FAIL reset_mid_wrap got=%0b exp=0", wrap); end
    n_clear = 1'b1;
    step();
    checks++; if (q !== 4'd1) begin errors++; $display("FAIL after_release got=%0d exp=1", q); end
  endtask

  task automatic test_up_wrap();
    do_reset();
    n_hold = 1'b1; up = 1'b1; load = 1'b0;
    for (int i = 0; i <= 10; i++) begin
      checks++; if (q !== 4'(i % 10)) begin errors++; $display("FAIL up_q[%0d] got=%0d exp=%0d", i, q, i % 10); end
      checks++; if (tc !== (i % 10 == 9)) begin errors++; $display("FAIL up_tc[%0d] got=%0b", i, tc); end
      checks++; if (wrap !== (i == 10)) begin errors++; $display("FAIL up_wrap[%0d] got=%0b", i, wrap); end
      step();
    end
    checks++; if (wrap !== 1'b0) begin errors++; $display("FAIL up_wrap_clear got=%0b exp=0", wrap); end
  endtask

  task automatic test_down_wrap();
    int seq[5] = '{2, 1, 0, 9, 8};
    load = 1'b1; d = 4'd2; n_hold = 1'b1; up = 1'b0;
    step();
    load = 1'b0; #1;
    for (int i = 0; i < 5; i++) begin
      checks++; if (q !== 4'(seq[i])) begin errors++; $display("FAIL down_q[%0d] got=%0d exp=%0d", i, q, seq[i]); end
      checks++; if (tc !== (seq[i] == 0)) begin errors++; $display("FAIL down_tc[%0d] got=%0b", i, tc); end
      checks++; if (wrap !== (i == 3)) begin errors++; $display("FAIL down_wrap[%0d] got=%0b", i, wrap); end
      step();
    end
  endtask

  task automatic test_hold_load();
    load = 1'b1; d = 4'd5; n_hold = 1'b1; up = 1'b1;
    step();
    load = 1'b0; n_hold = 1'b0;
    for (int i = 0; i < 3; i++) begin
      step();
      checks++; if (q !== 4'd5) begin errors++; $display("FAIL hold_q[%0d] got=%0d exp=5", i, q); end
      checks++; if (tc !== 1'b0) begin errors++; $display("FAIL hold_tc[%0d] got=%0b exp=0", i, tc); end
    end
    load = 1'b1; d = 4'd3;
    step();
    checks++; if (q !== 4'd3) begin errors++; $display("FAIL load_over_hold got=%0d exp=3", q); end
    load = 1'b0; n_hold = 1'b1;
  endtask

  task automatic test_out_of_range();
    load = 1'b1; d = 4'd12;
    step();
    checks++; if (q !== 4'd0) begin errors++; $display("FAIL load_12 got=%0d exp=0", q); end
    d = 4'd10;
    step();
    checks++; if (q !== 4'd0) begin errors++; $display("FAIL load_10 got=%0d exp=0", q); end
    d = 4'd9; up = 1'b1;
    step();
    checks++; if (q !== 4'd9) begin errors++; $display("FAIL load_9 got=%0d exp=9", q); end
    checks++; if (tc !== 1'b0) begin errors++; $display("FAIL tc_masked got=%0b exp=0", tc); end
    load = 1'b0; #1;
    checks++; if (tc !== 1'b1) begin errors++; $display("FAIL tc_unmasked got=%0b exp=1", tc); end
  endtask

  task automatic test_direction_change();
    load = 1'b1; d = 4'd3; n_hold = 1'b1; up = 1'b1;
    step();
    load = 1'b0;
    step();
    checks++; if (q !== 4'd4) begin errors++; $display("FAIL dir_up got=%0d exp=4", q); end
    up = 1'b0;
    step();
    checks++; if (q !== 4'd3) begin errors++; $display("FAIL dir_down got=%0d exp=3", q); end
  endtask

  task automatic test_cascade();
    int pulses = 0;
    c_clear = 1'b0; #2; c_clear = 1'b1; #1;
    repeat (25) step();
    checks++; if (hi_q !== 4'd2 || lo_q !== 4'd5) begin errors++; $display("FAIL cascade_25 got=%0d/%0d exp=2/5", hi_q, lo_q); end
    repeat (75) begin
      step();
      if (hi_wrap) pulses++;
    end
    checks++; if (hi_q !== 4'd0 || lo_q !== 4'd0) begin errors++; $display("FAIL cascade_100 got=%0d/%0d exp=0/0", hi_q, lo_q); end
    checks++; if (hi_wrap !== 1'b1) begin errors++; $display("FAIL cascade_hi_wrap got=%0b exp=1", hi_wrap); end
    checks++; if (pulses != 1) begin errors++; $display("FAIL cascade_pulses got=%0d exp=1", pulses); end
    step();
    checks++; if (hi_wrap !== 1'b0) begin errors++; $display("FAIL cascade_wrap_clear got=%0b exp=0", hi_wrap); end
  endtask

  initial begin
    c_clear = 1'b0;
    test_reset();
    test_up_wrap();
    test_down_wrap();
    test_hold_load();
    test_out_of_range();
    test_direction_change();
    test_cascade();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule

// File: doc/contador_modulo_hold.md
Name: contador_modulo_hold

Overview:
- Synchronous modulo-N up/down counter with hold and parallel load.
- Sits directly downstream of the team's T flip-flop-with-hold stage and is the register-transfer counterpart of a chain of those flip-flops.
- Q and TC feed the next counter in a cascade, or the display/decoder stages.
- All state changes occur on the falling edge of CLK, as in the existing flip-flop stages.

Parameters:
- WIDTH, 4: width of Q and D in bits.
- MODULO, 10: count sequence length. Legal range 2 <= MODULO <= 2**WIDTH.

Ports:
- CLK  input  1  clock; state updates on the falling edge.
- nCLEAR  input  1  asynchronous, active-low reset.
- nHOLD  input  1  active-low hold; 0 freezes the count.
- UP  input  1  direction; 1 = count up, 0 = count down.
- LOAD  input  1  synchronous parallel load strobe, active high.
- D  input  WIDTH  parallel load value.
- Q  output  WIDTH  current count, registered.
- TC  output  1  terminal count, combinational.
- WRAP  output  1  registered one-cycle pulse after a wrap-around.

Behaviour:
- Reset (nCLEAR=0):
  - Q=0 and WRAP=0 immediately, without waiting for CLK.
  - TC follows combinationally from Q=0.
  - Reset dominates all other inputs and holds for as long as nCLEAR=0.
- Reset release (nCLEAR 0->1):
  - No state change until the next falling CLK edge.
  - A release coincident with a falling edge does not count on that edge.
- Priority at each falling CLK edge with nCLEAR=1: LOAD > hold > count.
- LOAD=1:
  - Q <= D when D < MODULO; otherwise Q <= 0 (out-of-range loads clamp to 0).
  - LOAD overrides nHOLD=0.
  - WRAP <= 0.
- LOAD=0, nHOLD=0: Q and UP-independent state unchanged; WRAP <= 0.
- LOAD=0, nHOLD=1, UP=1: Q <= 0 if Q==MODULO-1, else Q+1.
- LOAD=0, nHOLD=1, UP=0: Q <= MODULO-1 if Q==0, else Q-1.
- WRAP:
  - Set to 1 on an edge where the count wrapped (MODULO-1 -> 0 up, or 0 -> MODULO-1 down).
  - Cleared on every other edge, so it is high for exactly one clock period.
- TC = nHOLD & ~LOAD & (UP ? Q==MODULO-1 : Q==0).
  - Purely combinational and glitch-tolerant by design.
  - Used as the count enable (drives nHOLD) of the next cascaded stage.
- Direction change mid-sequence: takes effect at the next counting edge; no extra latency.
- Arithmetic: modulo MODULO only. With MODULO=2**WIDTH the counter wraps naturally, with no illegal states.
- Q is never outside 0..MODULO-1 once reset has been applied.
- Latency: one falling edge from LOAD/count request to the updated Q.

Test Plan:
- Reset mid-count: Q=7, nCLEAR pulsed low between edges -> Q=0 and WRAP=0 immediately; after release with UP=1, nHOLD=1, the next edge gives Q=1.
- Up wrap (MODULO=10): count from 0 with UP=1 -> Q = 0,1,…,9,0; TC=1 only while Q=9; WRAP=1 for the single period after 9->0.
- Down wrap: load D=2, UP=0 -> Q = 2,1,0,9,8; TC=1 while Q=0; WRAP pulses after 0->9.
- Hold vs load: Q=5, nHOLD=0 for 3 edges -> Q stays 5 and TC=0. Then LOAD=1, D=3 with nHOLD=0 -> Q=3.
- Out-of-range load: D=12, LOAD=1 -> Q=0. Then D=9, LOAD=1, UP=1 -> Q=9, and TC=0 while LOAD=1 (LOAD masks TC).
- Cascade: two instances, TC of the low stage driving nHOLD of the high stage, both UP=1 -> after 25 edges from reset the high/low pair reads 2/5; after 100 edges both read 0 and the high stage's WRAP pulses once.
